// File: rtl/nanorv32_sim_ctrl_pkg.sv
// Shared definitions for the nanorv32 simulation-control peripheral:
// register offsets, end-of-test signatures, verdict codes and FSM states.
package nanorv32_sim_ctrl_pkg;

    localparam logic [3:0] AddrStatus  = 4'h0;
    localparam logic [3:0] AddrConsole = 4'h4;
    localparam logic [3:0] AddrInfo    = 4'h8;

    localparam logic [31:0] SigPass = 32'hCAFF_E000;
    localparam logic [31:0] SigFail = 32'h0DEA_D000;

    typedef enum logic [1:0] {
        CodeNone    = 2'd0,
        CodePass    = 2'd1,
        CodeFail    = 2'd2,
        CodeUnknown = 2'd3
    } test_code_e;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic test_code_e decode_signature(input logic [31:0] sig);
        if (sig == SigPass) begin
            return CodePass;
        end else if (sig == SigFail) begin
            return CodeFail;
        end
        return CodeUnknown;
    endfunction

endpackage

// File: rtl/nanorv32_sync_fifo.sv
// Generic synchronous FIFO with full/empty/level status; head word is driven
// as zero while empty so consumers see a clean value after reset.
module nanorv32_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]     wr_ptr_q, rd_ptr_q;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/nanorv32_sim_ctrl.sv
// Simulation-control peripheral: console FIFO, end-of-test verdict FSM and,
// when NANORV32_SIM_CTRL_WATCHDOG_EN is defined, a cycle watchdog.
module nanorv32_sim_ctrl
    import nanorv32_sim_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        test_done,
    output logic [1:0]  test_code,
    output logic        test_timeout
);

    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("nanorv32_sim_ctrl: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    state_e             state_q;
    test_code_e         code_q;
    logic               done_q;
    logic               timeout_q;

    logic               status_wr, console_wr, info_rd;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]         fifo_head;
    logic [LevelW-1:0]  fifo_level;
    logic               wd_expire;

    assign status_wr  = bus_sel & bus_we & (bus_addr == AddrStatus);
    assign console_wr = bus_sel & bus_we & (bus_addr == AddrConsole);
    assign info_rd    = bus_sel & ~bus_we & (bus_addr == AddrInfo);

    // Console writes are only stalled while running; after the verdict they are dropped.
    assign fifo_push = console_wr & (state_q == StRun) & ~fifo_full;
    assign fifo_pop  = con_valid & con_ready;
    assign bus_ready = ~(console_wr & (state_q == StRun) & fifo_full);

    nanorv32_sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_con_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign con_valid = ~fifo_empty;
    assign con_data  = fifo_head;

`ifdef NANORV32_SIM_CTRL_WATCHDOG_EN
    logic [31:0] wd_cnt_q;

    // Fires on the cycle the count would reach the limit, so DONE lands on that edge.
    assign wd_expire = (state_q != StDone) && (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (state_q != StDone) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            code_q    <= CodeNone;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (wd_expire) begin
            state_q   <= StDone;
            code_q    <= CodeUnknown;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (status_wr) begin
                        code_q  <= decode_signature(bus_wdata);
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign test_done    = done_q;
    assign test_code    = code_q;
    assign test_timeout = timeout_q;

    assign bus_rdata = info_rd ? {20'd0, timeout_q, done_q, code_q, 8'(fifo_level)} : 32'd0;

endmodule

// File: tb/tb_nanorv32_sim_ctrl.sv
// Scoreboard bench for nanorv32_sim_ctrl: stimulus queues expected console
// bytes and INFO reads; a negedge monitor pops and compares them.
module tb_nanorv32_sim_ctrl;

    logic        clk;
    logic        rst_n;
    logic        bus_sel;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        test_done;
    logic [1:0]  test_code;
    logic        test_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  exp_con[$];
    logic [31:0] exp_rd[$];

    nanorv32_sim_ctrl #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_sel      (bus_sel),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready    (bus_ready),
        .con_valid    (con_valid),
        .con_data     (con_data),
        .con_ready    (con_ready),
        .test_done    (test_done),
        .test_code    (test_code),
        .test_timeout (test_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n && con_valid && con_ready) begin
            if (exp_con.size() == 0) begin
                check("con_unexpected_byte", {24'd0, con_data}, 32'hFFFF_FFFF);
            end else begin
                check("con_data", {24'd0, con_data}, {24'd0, exp_con.pop_front()});
            end
        end
        if (rst_n && bus_sel && !bus_we && bus_ready) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", bus_rdata, 32'hFFFF_FFFF);
            end else begin
                check("info_rdata", bus_rdata, exp_rd.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        bus_wdata = 32'd0;
        con_ready = 1'b0;
        exp_con.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Entered and left at posedge+1; waits out any stall with a cycle bound.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        int n;
        n = 0;
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        @(negedge clk);
        while (!bus_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_ready) check("write_stall_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus_sel = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic info_read(input logic [31:0] exp);
        exp_rd.push_back(exp);
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 4'h8;
        @(posedge clk);
        #1;
        bus_sel = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Reset values
        do_reset();
        check("rst_bus_ready", {31'd0, bus_ready}, 32'd1);
        check("rst_con_valid", {31'd0, con_valid}, 32'd0);
        check("rst_con_data", {24'd0, con_data}, 32'd0);
        check("rst_test_done", {31'd0, test_done}, 32'd0);
        check("rst_test_code", {30'd0, test_code}, 32'd0);
        check("rst_test_timeout", {31'd0, test_timeout}, 32'd0);
        info_read(32'h0000_0000);

        // 'O','K' then pass signature with the console draining
        con_ready = 1'b1;
        exp_con.push_back(8'h4F);
        bus_write(4'h4, 32'h0000_004F);
        exp_con.push_back(8'h4B);
        bus_write(4'h4, 32'h0000_004B);
        bus_write(4'h0, 32'hCAFF_E000);
        check("pass_code", {30'd0, test_code}, 32'd1);
        check("pass_done_before_drain", {31'd0, test_done}, 32'd0);
        cycle();
        check("pass_done", {31'd0, test_done}, 32'd1);
        bus_write(4'h4, 32'h0000_0058);
        bus_write(4'h0, 32'h0DEA_D000);
        cycle();
        check("done_ignores_writes", {30'd0, test_code}, 32'd1);
        info_read(32'h0000_0500);

        // Fail signature with an empty FIFO
        do_reset();
        bus_write(4'hC, 32'h0000_0041);
        bus_write(4'h0, 32'h0DEA_D000);
        check("fail_code", {30'd0, test_code}, 32'd2);
        check("fail_done_early", {31'd0, test_done}, 32'd0);
        cycle();
        check("fail_done", {31'd0, test_done}, 32'd1);
        info_read(32'h0000_0600);

        // Unknown signature
        do_reset();
        bus_write(4'h0, 32'h1234_5678);
        check("unknown_code", {30'd0, test_code}, 32'd3);
        check("unknown_timeout", {31'd0, test_timeout}, 32'd0);
        cycle();
        info_read(32'h0000_0700);

        // Full FIFO backpressure
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_con.push_back(8'h30 + 8'(i));
            bus_write(4'h4, 32'h30 + 32'(i));
        end
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 4'h4;
        bus_wdata = 32'h0000_0038;
        @(negedge clk);
        check("full_stall", {31'd0, bus_ready}, 32'd0);
        cycle();
        con_ready = 1'b1;
        @(negedge clk);
        check("stall_during_pop", {31'd0, bus_ready}, 32'd0);
        cycle();
        con_ready = 1'b0;
        exp_con.push_back(8'h38);
        @(negedge clk);
        check("stall_released", {31'd0, bus_ready}, 32'd1);
        cycle();
        bus_sel = 1'b0;
        bus_we  = 1'b0;
        info_read(32'h0000_0008);
        con_ready = 1'b1;
        n = 0;
        while (con_valid && n < 40) begin
            cycle();
            n++;
        end
        check("drain_bound", {31'd0, con_valid}, 32'd0);
        con_ready = 1'b0;

        // Watchdog
        do_reset();
`ifdef NANORV32_SIM_CTRL_WATCHDOG_EN
        repeat (99) cycle();
        check("wd_done_early", {31'd0, test_done}, 32'd0);
        cycle();
        check("wd_done", {31'd0, test_done}, 32'd1);
        check("wd_code", {30'd0, test_code}, 32'd3);
        check("wd_timeout", {31'd0, test_timeout}, 32'd1);
        info_read(32'h0000_0F00);
`else
        repeat (120) cycle();
        check("nowd_done", {31'd0, test_done}, 32'd0);
        check("nowd_timeout", {31'd0, test_timeout}, 32'd0);
        info_read(32'h0000_0000);
`endif

        // Reset during drain
        do_reset();
        bus_write(4'h4, 32'h0000_0061);
        bus_write(4'h4, 32'h0000_0062);
        bus_write(4'h4, 32'h0000_0063);
        bus_write(4'h0, 32'hCAFF_E000);
        check("drain_code", {30'd0, test_code}, 32'd1);
        check("drain_valid", {31'd0, con_valid}, 32'd1);
        check("drain_not_done", {31'd0, test_done}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, con_valid}, 32'd0);
        check("async_rst_code", {30'd0, test_code}, 32'd0);
        check("async_rst_data", {24'd0, con_data}, 32'd0);
        cycle();
        rst_n = 1'b1;
        info_read(32'h0000_0000);

        cycle();
        check("con_queue_empty", exp_con.size(), 32'd0);
        check("rd_queue_empty", exp_rd.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
